// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx -- asynchronous serial transmitter with a one-entry hold register.
//
// A word (5..8 bits, LSB first) is framed as: start(0), data, optional parity,
// one or two stop bits(1). Line timing comes entirely from the external bit
// strobe 'tick'; the FSM only advances on tick cycles, so each line bit lasts
// exactly one tick period. Word length, parity and stop configuration are
// captured with the data at acceptance and travel with the frame.
//
// Ports
//   clk         clock, all state changes on rising edge
//   rst         asynchronous active-high reset
//   enable      transmitter enable; low aborts the frame and drops the hold
//   tick        one-cycle bit-period strobe from the baud generator
//   data_bits   word length code: 0..3 -> 5..8 bits
//   parity_en   append a parity bit
//   parity_odd  odd (1) / even (0) parity
//   stop2       two stop bits (1) / one stop bit (0)
//   tx_data     word to send, bits above the word length ignored
//   tx_valid    producer offers tx_data
//   tx_ready    combinational: enable and hold register empty
//   txd         registered serial line, idle high
//   busy        frame in flight or word waiting in the hold register
//   frame_done  one-cycle pulse after the last stop bit of a frame
// -----------------------------------------------------------------------------
module uart_tx (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       tick,
    input  logic [1:0] data_bits,
    input  logic       parity_en,
    input  logic       parity_odd,
    input  logic       stop2,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       txd,
    output logic       busy,
    output logic       frame_done
);

    // Word plus its framing configuration, as captured at acceptance.
    typedef struct packed {
        logic [7:0] data;      // already masked to the word length
        logic [1:0] bits;
        logic       par_en;
        logic       par_odd;
        logic       stop2;
    } hold_t;

    // Per-frame working set for the frame currently on the line.
    typedef struct packed {
        logic [7:0] shift;     // remaining data bits, next one in [0]
        logic [2:0] last_bit;  // index of the final data bit (N-1)
        logic       par_bit;   // precomputed parity bit
        logic       par_en;
        logic       stop2;
    } frame_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t     state_q,    state_d;
    hold_t      hold_q;
    hold_t      hold_cap;
    logic       hold_full_q, hold_full_d;
    frame_t     cur_q,      cur_d;
    logic [2:0] bit_cnt_q,  bit_cnt_d;
    logic       stop_cnt_q, stop_cnt_d;
    logic       txd_q,      txd_d;
    logic       done_q,     done_d;

    logic       accept;
    logic       load;
    logic [7:0] word_mask;

    assign tx_ready   = enable && !hold_full_q;
    assign accept     = tx_valid && tx_ready;
    assign busy       = (state_q != IDLE) || hold_full_q;
    assign txd        = txd_q;
    assign frame_done = done_q;

    // Bits above the word length are cleared on capture so that parity can be
    // taken over the whole byte and the shift register needs no length mask.
    assign word_mask = 8'hFF >> (2'd3 - data_bits);

    always_comb begin
        hold_cap         = '0;
        hold_cap.data    = tx_data & word_mask;
        hold_cap.bits    = data_bits;
        hold_cap.par_en  = parity_en;
        hold_cap.par_odd = parity_odd;
        hold_cap.stop2   = stop2;
    end

    // -------------------------------------------------------------------------
    // Next-state / output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        txd_d      = txd_q;
        done_d     = 1'b0;
        load       = 1'b0;

        if (!enable) begin
            // Abort outranks tick: line back to idle, nothing reported.
            state_d    = IDLE;
            txd_d      = 1'b1;
            bit_cnt_d  = '0;
            stop_cnt_d = 1'b0;
        end else if (tick) begin
            case (state_q)
                IDLE: begin
                    txd_d = 1'b1;
                    if (hold_full_q) load = 1'b1;
                end
                START: begin
                    txd_d       = cur_q.shift[0];
                    cur_d.shift = cur_q.shift >> 1;
                    bit_cnt_d   = '0;
                    state_d     = DATA;
                end
                DATA: begin
                    if (bit_cnt_q != cur_q.last_bit) begin
                        txd_d       = cur_q.shift[0];
                        cur_d.shift = cur_q.shift >> 1;
                        bit_cnt_d   = bit_cnt_q + 3'd1;
                    end else if (cur_q.par_en) begin
                        txd_d   = cur_q.par_bit;
                        state_d = PARITY;
                    end else begin
                        txd_d      = 1'b1;
                        stop_cnt_d = 1'b0;
                        state_d    = STOP;
                    end
                end
                PARITY: begin
                    txd_d      = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = STOP;
                end
                STOP: begin
                    if (cur_q.stop2 && !stop_cnt_q) begin
                        stop_cnt_d = 1'b1;
                    end else begin
                        done_d = 1'b1;
                        if (hold_full_q) begin
                            // Chain straight into the next start bit.
                            load = 1'b1;
                        end else begin
                            txd_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    txd_d   = 1'b1;
                    state_d = IDLE;
                end
            endcase
        end

        // Hold-to-shift transfer: start bit goes on the line this edge.
        if (load) begin
            cur_d.shift    = hold_q.data;
            cur_d.last_bit = {1'b0, hold_q.bits} + 3'd4;
            cur_d.par_bit  = (^hold_q.data) ^ hold_q.par_odd;
            cur_d.par_en   = hold_q.par_en;
            cur_d.stop2    = hold_q.stop2;
            bit_cnt_d      = '0;
            stop_cnt_d     = 1'b0;
            txd_d          = 1'b0;
            state_d        = START;
        end

        // tx_ready is low while full, so accept and load are exclusive.
        if (!enable)     hold_full_d = 1'b0;
        else if (accept) hold_full_d = 1'b1;
        else if (load)   hold_full_d = 1'b0;
        else             hold_full_d = hold_full_q;
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            bit_cnt_q   <= '0;
            stop_cnt_q  <= 1'b0;
            txd_q       <= 1'b1;
            done_q      <= 1'b0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            bit_cnt_q   <= bit_cnt_d;
            stop_cnt_q  <= stop_cnt_d;
            txd_q       <= txd_d;
            done_q      <= done_d;
            hold_full_q <= hold_full_d;
        end
    end

    // Hold payload needs no reset; hold_full_q qualifies it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         hold_q <= '0;
        else if (accept) hold_q <= hold_cap;
    end

endmodule
